// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core definitions.
// - AluOP codes decoded by the control unit.
// - Multiply/divide sequencer state encoding.
package cpu_pkg;

  localparam logic [5:0] ALUOP_ADD = 6'b000000;
  localparam logic [5:0] ALUOP_SUB = 6'b000001;
  localparam logic [5:0] ALUOP_MUL = 6'b000010;
  localparam logic [5:0] ALUOP_DIV = 6'b000011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle between EX and the mul/div sequencer.
// master (EX side):   drives start, alu_op, operand_a, operand_b;
//                     receives stall, busy, done, result, div_by_zero.
// slave (sequencer):  the mirror image.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       alu_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, alu_op, operand_a, operand_b,
    input  stall, busy, done, result, div_by_zero
  );

  modport slave (
    input  start, alu_op, operand_a, operand_b,
    output stall, busy, done, result, div_by_zero
  );
endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared shift/add-subtract datapath, one bit per i_step.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_load          latch operand magnitudes, sign and op
//   i_is_div        op to latch on i_load (1 = divide, 0 = multiply)
//   i_a, i_b        two's complement operands
//   i_step          perform one iteration
//   o_result        sign-corrected result as it will be after the current step
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_result
);

  // Register roles:
  //   multiply: r_acc = partial product, r_x = multiplicand (<<), r_y = multiplier (>>)
  //   divide:   r_acc = remainder, r_x = divisor, r_y = dividend shifting into quotient
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_is_div;
  logic             r_neg;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_n;
  logic [WIDTH-1:0] w_x_n;
  logic [WIDTH-1:0] w_y_n;
  logic [WIDTH-1:0] w_raw;

  // Most-negative input keeps its bit pattern, which is its correct unsigned magnitude.
  assign w_mag_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_mag_b = i_b[WIDTH-1] ? -i_b : i_b;

  always_comb begin
    w_sh    = {r_acc, r_y[WIDTH-1]};
    w_diff  = w_sh - {1'b0, r_x};
    w_ge    = ~w_diff[WIDTH];
    w_acc_n = r_acc;
    w_x_n   = r_x;
    w_y_n   = r_y;
    w_raw   = '0;
    if (r_is_div) begin
      // Restoring divide: keep the trial difference only when it did not borrow.
      w_acc_n = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
      w_y_n   = {r_y[WIDTH-2:0], w_ge};
      w_raw   = w_y_n;
    end else begin
      w_acc_n = r_acc + (r_y[0] ? r_x : '0);
      w_x_n   = r_x << 1;
      w_y_n   = r_y >> 1;
      w_raw   = w_acc_n;
    end
  end

  assign o_result = r_neg ? -w_raw : w_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_x      <= w_mag_b;
      r_y      <= w_mag_a;
      r_is_div <= i_is_div;
      r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
    end else if (i_step) begin
      r_acc    <= w_acc_n;
      r_x      <= w_x_n;
      r_y      <= w_y_n;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MUL/DIV unit beside the EX-stage ALU.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        muldiv_sequencer_if.slave:
//                start/alu_op/operand_a/operand_b in,
//                stall (combinational), busy, done, result, div_by_zero out
// Accepts in IDLE or DONE, runs WIDTH iterations, pulses done for one cycle.
// A zero divisor skips the iterations and completes the next cycle.
module muldiv_sequencer
  import cpu_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter logic [5:0] ALU_MUL = ALUOP_MUL,
  parameter logic [5:0] ALU_DIV = ALUOP_DIV
) (
  input logic              clk,
  input logic              rst,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  seq_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_accept;
  logic             w_div0;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_dp_result;

  assign w_is_mul = (bus.alu_op == ALU_MUL);
  assign w_is_div = (bus.alu_op == ALU_DIV);
  assign w_accept = bus.start && (w_is_mul || w_is_div) && (r_state != RUN);
  assign w_div0   = w_is_div && (bus.operand_b == '0);
  assign w_step   = (r_state == RUN);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_is_div (w_is_div),
    .i_a      (bus.operand_a),
    .i_b      (bus.operand_b),
    .i_step   (w_step),
    .o_result (w_dp_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // Datapath output already reflects this final step.
            r_result <= w_dp_result;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        IDLE, DONE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_div0) begin
              r_result <= '1;
              r_dbz    <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_dbz;
  assign bus.stall       = r_busy | w_accept;

endmodule
